// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants for the 640x480@60 VGA pipeline: default porch,
// sync and active widths, helpers that derive the line/frame totals, the
// colour depth and the bit positions of each signal inside uo_out, which is
// packed as {hsync, B0, G0, R0, vsync, B1, G1, R1}.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Position counters are 10 bits, so neither total may exceed 1024.
    localparam int COUNT_W     = 10;
    localparam int COUNT_LIMIT = 1 << COUNT_W;

    // 640x480@60 defaults (pixels / lines).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Colour depth per channel (two bits each for R, G and B).
    localparam int COLOR_BITS = 2;

    // Bit positions within uo_out, shared with the output packer.
    localparam int UO_R1_BIT    = 0;
    localparam int UO_G1_BIT    = 1;
    localparam int UO_B1_BIT    = 2;
    localparam int UO_VSYNC_BIT = 3;
    localparam int UO_R0_BIT    = 4;
    localparam int UO_G0_BIT    = 5;
    localparam int UO_B0_BIT    = 6;
    localparam int UO_HSYNC_BIT = 7;

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// 10-bit up counter that counts 0..MAX and wraps to 0. Reset loads MAX so
// the first enabled edge after reset produces 0.
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset (loads MAX)
//   en         in  count enable; counter holds when low
//   count      out current count (flop Q)
//   count_next out value the counter takes on the next edge
//   wrap       out high while count == MAX (next enabled edge wraps to 0)
// ---------------------------------------------------------------------------
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter logic [COUNT_W-1:0] MAX = COUNT_W'(799)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] count_next,
    output logic               wrap
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    assign wrap = (count_q == MAX);

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= MAX;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// Pixel-clock timing generator: pixel/line counters plus registered sync,
// blanking and start-of-line/frame strobes. Every output is a flop Q and all
// of them describe the same (hpos, vpos) on any cycle.
// Ports:
//   clk         in  pixel clock
//   rst_n       in  asynchronous active-low reset
//   ena         in  count enable; all registers hold while low
//   hpos        out current pixel column, 0..H_TOTAL-1
//   vpos        out current line, 0..V_TOTAL-1
//   hsync       out horizontal sync, at level SYNC_POL while asserted
//   vsync       out vertical sync, at level SYNC_POL while asserted
//   display_on  out high inside the visible area
//   line_start  out high while hpos == 0
//   frame_start out high while hpos == 0 and vpos == 0
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [COUNT_W-1:0] hpos,
    output logic [COUNT_W-1:0] vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COUNT_LIMIT) begin : g_h_total_too_large
        $error("vga_sync_gen: H_TOTAL exceeds the 10-bit counter range");
    end
    if (V_TOTAL > COUNT_LIMIT) begin : g_v_total_too_large
        $error("vga_sync_gen: V_TOTAL exceeds the 10-bit counter range");
    end

    localparam logic [COUNT_W-1:0] H_MAX      = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_MAX      = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_ACT_END  = COUNT_W'(H_ACTIVE);
    localparam logic [COUNT_W-1:0] V_ACT_END  = COUNT_W'(V_ACTIVE);
    localparam logic [COUNT_W-1:0] HS_START   = COUNT_W'(H_ACTIVE + H_FP);
    localparam logic [COUNT_W-1:0] HS_END     = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COUNT_W-1:0] VS_START   = COUNT_W'(V_ACTIVE + V_FP);
    localparam logic [COUNT_W-1:0] VS_END     = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [COUNT_W-1:0] h_count, h_next;
    logic [COUNT_W-1:0] v_count, v_next;
    logic               h_wrap, v_wrap;
    logic               v_en;

    // The line counter only advances on the pixel edge that wraps hpos.
    assign v_en = ena & h_wrap;

    wrap_counter #(.MAX(H_MAX)) u_h_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (ena),
        .count      (h_count),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    wrap_counter #(.MAX(V_MAX)) u_v_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (v_en),
        .count      (v_count),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic display_on_q, display_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Decode from the counters' next values so the registered strobes land
    // on the same edge as the hpos/vpos they describe. v_next only moves on
    // the hpos wrap, so vsync is inherently line-aligned.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        display_on_d  = display_on_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (ena) begin
            hsync_d       = (h_next >= HS_START && h_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_next >= VS_START && v_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
            display_on_d  = (h_next < H_ACT_END) && (v_next < V_ACT_END);
            // Next position is (0, *) exactly when hpos is wrapping, and
            // (0, 0) when both counters are at their maximum.
            line_start_d  = h_wrap;
            frame_start_d = h_wrap & v_wrap;
        end
    end

    // Reset state matches the last pixel of a frame, so the first enabled
    // edge presents (0,0) with every start strobe high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hpos        = h_count;
    assign vpos        = v_count;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Two instances share clock, reset and enable: the default 640x480 timing
// (800 x 525, negative sync) and a reduced 32 x 19 timing with positive
// sync so whole frames fit in a short run.
// Small timing: H 16/4/6/6 (hsync on 20..25), V 12/2/2/3 (vsync on 14..15).
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;

    logic [9:0] d_hpos, d_vpos, s_hpos, s_vpos;
    logic       d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start;
    logic       s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start;
    logic [24:0] d_vec, s_vec;

    int checks = 0;
    int errors = 0;
    int n_en   = 0;   // enabled edges since the last reset release

    always #5 clk = ~clk;

    vga_sync_gen u_dut_def (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .hpos        (d_hpos),
        .vpos        (d_vpos),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .display_on  (d_display_on),
        .line_start  (d_line_start),
        .frame_start (d_frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) u_dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .hpos        (s_hpos),
        .vpos        (s_vpos),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .display_on  (s_display_on),
        .line_start  (s_line_start),
        .frame_start (s_frame_start)
    );

    assign d_vec = {d_hpos, d_vpos, d_hsync, d_vsync, d_display_on, d_line_start, d_frame_start};
    assign s_vec = {s_hpos, s_vpos, s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start};

    // Expected {hpos, vpos, hsync, vsync, display_on, line_start, frame_start}
    // after n enabled edges (n >= 1) for the default timing.
    function automatic logic [24:0] exp_d(input int n);
        int k, h, v;
        k = n - 1;
        h = k % 800;
        v = (k / 800) % 525;
        return {10'(h), 10'(v), !(h >= 656 && h <= 751), !(v >= 490 && v <= 491),
                (h < 640 && v < 480), (h == 0), (h == 0 && v == 0)};
    endfunction

    // Same for the reduced timing (positive sync).
    function automatic logic [24:0] exp_s(input int n);
        int k, h, v;
        k = n - 1;
        h = k % 32;
        v = (k / 32) % 19;
        return {10'(h), 10'(v), (h >= 20 && h <= 25), (v >= 14 && v <= 15),
                (h < 16 && v < 12), (h == 0), (h == 0 && v == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n && ena) n_en++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) tick();
        checks++;
        if (d_vec !== {10'd799, 10'd524, 1'b1, 1'b1, 3'b000}) begin
            errors++; $display("FAIL reset_def: got %h expected %h", d_vec, {10'd799, 10'd524, 1'b1, 1'b1, 3'b000});
        end
        checks++;
        if (s_vec !== {10'd31, 10'd18, 1'b0, 1'b0, 3'b000}) begin
            errors++; $display("FAIL reset_small: got %h expected %h", s_vec, {10'd31, 10'd18, 1'b0, 1'b0, 3'b000});
        end
        rst_n = 1'b1;
        n_en  = 0;
        tick();
        checks++;
        if (d_vec !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b111}) begin
            errors++; $display("FAIL first_edge_def: got %h expected %h", d_vec, {10'd0, 10'd0, 1'b1, 1'b1, 3'b111});
        end
        checks++;
        if (s_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 3'b111}) begin
            errors++; $display("FAIL first_edge_small: got %h expected %h", s_vec, {10'd0, 10'd0, 1'b0, 1'b0, 3'b111});
        end
    endtask

    // One full default line: hsync window, display_on fall at 640, wrap to
    // (0,1) without a frame_start.
    task automatic test_line_scan();
        for (int i = 0; i < 800; i++) begin
            tick();
            checks++;
            if (d_vec !== exp_d(n_en)) begin
                errors++; $display("FAIL line_scan n=%0d: got %h expected %h", n_en, d_vec, exp_d(n_en));
            end
        end
        checks++;
        if (d_hpos !== 10'd0 || d_vpos !== 10'd1 || d_frame_start !== 1'b0) begin
            errors++; $display("FAIL line_wrap: got h=%0d v=%0d fs=%b expected h=0 v=1 fs=0", d_hpos, d_vpos, d_frame_start);
        end
    endtask

    // One full reduced frame, every cycle checked, plus pulse/display counts.
    task automatic test_frame_scan();
        int cyc, ls_cnt, de_cnt, fs_cnt;
        cyc = 0; ls_cnt = 0; de_cnt = 0; fs_cnt = 0;
        while (s_frame_start !== 1'b1 && cyc < 700) begin
            tick(); cyc++;
        end
        checks++;
        if (s_frame_start !== 1'b1) begin
            errors++; $display("FAIL frame_wait: got frame_start=%b expected 1 within 700 cycles", s_frame_start);
        end
        for (int i = 0; i < 608; i++) begin
            tick();
            checks++;
            if (s_vec !== exp_s(n_en)) begin
                errors++; $display("FAIL frame_scan n=%0d: got %h expected %h", n_en, s_vec, exp_s(n_en));
            end
            if (s_line_start === 1'b1) ls_cnt++;
            if (s_display_on === 1'b1) de_cnt++;
            if (s_frame_start === 1'b1) fs_cnt++;
        end
        checks++;
        if (fs_cnt !== 1 || s_frame_start !== 1'b1) begin
            errors++; $display("FAIL frame_period: got %0d pulses, fs=%b expected 1 pulse at cycle 608", fs_cnt, s_frame_start);
        end
        checks++;
        if (ls_cnt !== 19) begin
            errors++; $display("FAIL line_pulses: got %0d expected 19", ls_cnt);
        end
        checks++;
        if (de_cnt !== 192) begin
            errors++; $display("FAIL display_count: got %0d expected 192", de_cnt);
        end
    endtask

    // Hold at hpos 655 for 37 cycles; the line then lasts 837 clocks.
    task automatic test_ena_hold();
        int cyc;
        bit held;
        cyc = 0; held = 0;
        while (d_line_start !== 1'b1 && cyc < 900) begin
            tick(); cyc++;
        end
        checks++;
        if (d_line_start !== 1'b1) begin
            errors++; $display("FAIL hold_wait: got line_start=%b expected 1 within 900 cycles", d_line_start);
        end
        cyc = 0;
        while (cyc < 2000) begin
            if (d_hpos == 10'd655 && !held) begin
                ena = 1'b0;
                for (int i = 0; i < 37; i++) begin
                    tick(); cyc++;
                    checks++;
                    if (d_hpos !== 10'd655 || d_hsync !== 1'b1 || d_vec !== exp_d(n_en)) begin
                        errors++; $display("FAIL hold_def i=%0d: got %h expected %h", i, d_vec, exp_d(n_en));
                    end
                end
                ena  = 1'b1;
                held = 1;
                tick(); cyc++;
                checks++;
                if (d_hpos !== 10'd656 || d_hsync !== 1'b0) begin
                    errors++; $display("FAIL hold_resume: got h=%0d hsync=%b expected h=656 hsync=0", d_hpos, d_hsync);
                end
            end else begin
                tick(); cyc++;
            end
            if (d_line_start === 1'b1) break;
        end
        checks++;
        if (cyc !== 837) begin
            errors++; $display("FAIL hold_line_period: got %0d expected 837", cyc);
        end
    endtask

    // Hold mid-frame on the reduced timing; the frame then lasts 608+37.
    task automatic test_frame_hold();
        int cyc;
        bit held;
        cyc = 0; held = 0;
        while (s_frame_start !== 1'b1 && cyc < 700) begin
            tick(); cyc++;
        end
        checks++;
        if (s_frame_start !== 1'b1) begin
            errors++; $display("FAIL fhold_wait: got frame_start=%b expected 1 within 700 cycles", s_frame_start);
        end
        cyc = 0;
        while (cyc < 1000) begin
            if (s_hpos == 10'd19 && s_vpos == 10'd5 && !held) begin
                ena = 1'b0;
                for (int i = 0; i < 37; i++) begin
                    tick(); cyc++;
                    checks++;
                    if (s_vec !== exp_s(n_en)) begin
                        errors++; $display("FAIL fhold_small i=%0d: got %h expected %h", i, s_vec, exp_s(n_en));
                    end
                end
                ena  = 1'b1;
                held = 1;
                tick(); cyc++;
                checks++;
                if (s_hpos !== 10'd20 || s_hsync !== 1'b1) begin
                    errors++; $display("FAIL fhold_resume: got h=%0d hsync=%b expected h=20 hsync=1", s_hpos, s_hsync);
                end
            end else begin
                tick(); cyc++;
            end
            if (s_frame_start === 1'b1) break;
        end
        checks++;
        if (cyc !== 645) begin
            errors++; $display("FAIL fhold_frame_period: got %0d expected 645", cyc);
        end
    endtask

    // Async reset between clock edges at default (300, *) / small (12, 7).
    task automatic test_reset_mid();
        int cyc;
        cyc = 0;
        while (!(d_hpos == 10'd300 && s_hpos == 10'd12 && s_vpos == 10'd7) && cyc < 16000) begin
            tick(); cyc++;
        end
        checks++;
        if (d_hpos !== 10'd300 || s_hpos !== 10'd12 || s_vpos !== 10'd7) begin
            errors++; $display("FAIL rmid_wait: got d_h=%0d s_h=%0d s_v=%0d expected 300/12/7", d_hpos, s_hpos, s_vpos);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (d_vec !== {10'd799, 10'd524, 1'b1, 1'b1, 3'b000}) begin
            errors++; $display("FAIL rmid_async_def: got %h expected %h", d_vec, {10'd799, 10'd524, 1'b1, 1'b1, 3'b000});
        end
        checks++;
        if (s_vec !== {10'd31, 10'd18, 1'b0, 1'b0, 3'b000}) begin
            errors++; $display("FAIL rmid_async_small: got %h expected %h", s_vec, {10'd31, 10'd18, 1'b0, 1'b0, 3'b000});
        end
        tick();
        rst_n = 1'b1;
        n_en  = 0;
        tick();
        checks++;
        if (d_vec !== {10'd0, 10'd0, 1'b1, 1'b1, 3'b111}) begin
            errors++; $display("FAIL rmid_restart_def: got %h expected %h", d_vec, {10'd0, 10'd0, 1'b1, 1'b1, 3'b111});
        end
        checks++;
        if (s_vec !== {10'd0, 10'd0, 1'b0, 1'b0, 3'b111}) begin
            errors++; $display("FAIL rmid_restart_small: got %h expected %h", s_vec, {10'd0, 10'd0, 1'b0, 1'b0, 3'b111});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        test_reset();
        test_line_scan();
        test_frame_scan();
        test_ena_hold();
        test_frame_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
